// File: rtl/dma_pkg.sv
// Shared definitions for the DMA burst controller slice.
//   - Default word width and burst length.
//   - FSM state encoding (3 bits).
//   - lane_lsb(): maps a lane index to the LSB position of its word within a
//     device line, where lane 0 is the most significant word.
package dma_pkg;

    localparam int unsigned DEFAULT_WORD_SIZE = 16;
    localparam int unsigned DEFAULT_BURST_LEN = 4;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_REQ     = 3'd1,
        S_FETCH   = 3'd2,
        S_WRITE   = 3'd3,
        S_HOLD    = 3'd4,
        S_RELEASE = 3'd5,
        S_DONE    = 3'd6
    } dma_state_e;

    function automatic int unsigned lane_lsb(input int unsigned lane,
                                             input int unsigned burst_len,
                                             input int unsigned word_size);
        return (burst_len - 1 - lane) * word_size;
    endfunction

endpackage

// File: rtl/dma_line_buffer.sv
// Device line capture register with an MSB-first word selector.
// Ports:
//   clk      in   clock
//   reset_n  in   synchronous active-low reset (clears the line)
//   load     in   capture line_in on this edge
//   line_in  in   device line, word 0 in the most significant position
//   lane     in   word index to present on word_out
//   word_out out  selected word of the captured line
module dma_line_buffer
    import dma_pkg::*;
#(
    parameter int unsigned WORD_SIZE = DEFAULT_WORD_SIZE,
    parameter int unsigned BURST_LEN = DEFAULT_BURST_LEN,
    parameter int unsigned LANE_W    = $clog2(BURST_LEN)
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           load,
    input  logic [WORD_SIZE*BURST_LEN-1:0] line_in,
    input  logic [LANE_W-1:0]              lane,
    output logic [WORD_SIZE-1:0]           word_out
);

    logic [WORD_SIZE*BURST_LEN-1:0] line_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            line_q <= '0;
        end else if (load) begin
            line_q <= line_in;
        end
    end

    always_comb begin
        word_out = '0;
        for (int unsigned i = 0; i < BURST_LEN; i++) begin
            if (lane == LANE_W'(i)) begin
                word_out = line_q[lane_lsb(i, BURST_LEN, WORD_SIZE) +: WORD_SIZE];
            end
        end
    end

endmodule

// File: rtl/dma_burst_controller.sv
// DMA engine: copies cmd_length words from the device buffer into memory
// starting at cmd_addr, one device line (BURST_LEN words) at a time, while
// holding the bus through the BR/BG handshake. Pulses dma_done on completion.
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   cmd_valid/addr/length CPU command; accepted when cmd_ready is high
//   cmd_ready             high in IDLE
//   bus_request/bus_grant arbiter handshake
//   dev_offset/dev_data   device line fetch (offset is 0 outside FETCH)
//   mem_address/data      memory write port, mem_write held until mem_ack
//   dma_done              one-cycle completion pulse
module dma_burst_controller
    import dma_pkg::*;
#(
    parameter int unsigned WORD_SIZE   = DEFAULT_WORD_SIZE,
    parameter int unsigned BURST_LEN   = DEFAULT_BURST_LEN,
    parameter int unsigned DEV_LATENCY = 1
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           cmd_valid,
    input  logic [WORD_SIZE-1:0]           cmd_addr,
    input  logic [WORD_SIZE-1:0]           cmd_length,
    output logic                           cmd_ready,
    output logic                           bus_request,
    input  logic                           bus_grant,
    output logic [WORD_SIZE-1:0]           dev_offset,
    input  logic [WORD_SIZE*BURST_LEN-1:0] dev_data,
    output logic [WORD_SIZE-1:0]           mem_address,
    output logic [WORD_SIZE-1:0]           mem_data,
    output logic                           mem_write,
    input  logic                           mem_ack,
    output logic                           dma_done
);

    localparam int unsigned LANE_W = $clog2(BURST_LEN);
    localparam int unsigned CNT_W  = $clog2(BURST_LEN + 1);
    localparam int unsigned LAT_W  = 3;

    dma_state_e           state_q, state_d;
    logic [WORD_SIZE-1:0] addr_q, addr_d;
    logic [WORD_SIZE-1:0] len_q, len_d;
    logic [WORD_SIZE-1:0] done_q, done_d;
    logic [CNT_W-1:0]     lane_q, lane_d;
    logic [CNT_W-1:0]     burst_q, burst_d;
    logic [LAT_W-1:0]     lat_q, lat_d;

    logic                 load_line;
    logic [WORD_SIZE-1:0] word_out;
    logic [WORD_SIZE-1:0] remaining;
    logic [WORD_SIZE-1:0] done_inc;
    logic [CNT_W-1:0]     lane_inc;
    logic [CNT_W-1:0]     burst_next;

    dma_line_buffer #(
        .WORD_SIZE (WORD_SIZE),
        .BURST_LEN (BURST_LEN),
        .LANE_W    (LANE_W)
    ) u_line (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (load_line),
        .line_in  (dev_data),
        .lane     (lane_q[LANE_W-1:0]),
        .word_out (word_out)
    );

    assign remaining = len_q - done_q;
    assign done_inc  = done_q + WORD_SIZE'(1);
    assign lane_inc  = lane_q + CNT_W'(1);
    // Words in the line being fetched: a full burst, or what is left.
    assign burst_next = (remaining >= WORD_SIZE'(BURST_LEN)) ? CNT_W'(BURST_LEN)
                                                             : remaining[CNT_W-1:0];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            done_q  <= '0;
            lane_q  <= '0;
            burst_q <= '0;
            lat_q   <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            len_q   <= len_d;
            done_q  <= done_d;
            lane_q  <= lane_d;
            burst_q <= burst_d;
            lat_q   <= lat_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        len_d       = len_q;
        done_d      = done_q;
        lane_d      = lane_q;
        burst_d     = burst_q;
        lat_d       = lat_q;
        load_line   = 1'b0;
        cmd_ready   = 1'b0;
        bus_request = 1'b0;
        dev_offset  = '0;
        mem_address = '0;
        mem_data    = '0;
        mem_write   = 1'b0;
        dma_done    = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    addr_d  = cmd_addr;
                    len_d   = cmd_length;
                    done_d  = '0;
                    state_d = (cmd_length == '0) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                bus_request = 1'b1;
                if (bus_grant) begin
                    lat_d   = '0;
                    state_d = S_FETCH;
                end
            end
            S_FETCH: begin
                bus_request = 1'b1;
                dev_offset  = done_q;
                if (lat_q == LAT_W'(DEV_LATENCY - 1)) begin
                    // The line is captured even if grant was lost meanwhile;
                    // the writes then wait in HOLD.
                    load_line = 1'b1;
                    lane_d    = '0;
                    burst_d   = burst_next;
                    state_d   = bus_grant ? S_WRITE : S_HOLD;
                end else begin
                    lat_d = lat_q + LAT_W'(1);
                end
            end
            S_WRITE: begin
                bus_request = 1'b1;
                mem_write   = 1'b1;
                mem_address = addr_q + done_q;
                mem_data    = word_out;
                if (mem_ack) begin
                    done_d = done_inc;
                    lane_d = lane_inc;
                    if (done_inc == len_q) begin
                        state_d = S_RELEASE;
                    end else if (lane_inc == burst_q) begin
                        lat_d   = '0;
                        state_d = S_FETCH;
                    end else if (!bus_grant) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                bus_request = 1'b1;
                if (bus_grant) begin
                    state_d = S_WRITE;
                end
            end
            S_RELEASE: begin
                state_d = S_DONE;
            end
            S_DONE: begin
                dma_done = 1'b1;
                state_d  = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dma_burst_controller.sv
// Self-checking bench for dma_burst_controller: a reference model pushes the
// required memory writes into a scoreboard queue when a command is issued, and
// a monitor pops and compares on every accepted write.
module tb_dma_burst_controller;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic [15:0] cmd_addr = '0;
    logic [15:0] cmd_length = '0;
    logic        cmd_ready;
    logic        bus_request;
    logic        bus_grant = 1'b1;
    logic [15:0] dev_offset;
    logic [63:0] dev_data;
    logic [15:0] mem_address;
    logic [15:0] mem_data;
    logic        mem_write;
    logic        mem_ack = 1'b0;
    logic        dma_done;

    dma_burst_controller #(
        .WORD_SIZE   (16),
        .BURST_LEN   (4),
        .DEV_LATENCY (1)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .cmd_valid   (cmd_valid),
        .cmd_addr    (cmd_addr),
        .cmd_length  (cmd_length),
        .cmd_ready   (cmd_ready),
        .bus_request (bus_request),
        .bus_grant   (bus_grant),
        .dev_offset  (dev_offset),
        .dev_data    (dev_data),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_write   (mem_write),
        .mem_ack     (mem_ack),
        .dma_done    (dma_done)
    );

    always #5 clk = ~clk;

    // Device buffer: word i of the transfer lives at dev_mem[i mod 64].
    logic [15:0] dev_mem [64];
    logic [5:0]  doff;
    assign doff     = dev_offset[5:0];
    assign dev_data = {dev_mem[doff], dev_mem[doff + 6'd1],
                       dev_mem[doff + 6'd2], dev_mem[doff + 6'd3]};

    typedef struct {
        logic [15:0] a;
        logic [15:0] d;
    } wr_t;

    wr_t exp_q[$];
    wr_t e;
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;

    // Monitor-side observations, cleared by the job tasks.
    int  done_cnt = 0;
    int  done_cyc = 0;
    int  wr_cnt = 0;
    bit  br_seen = 0;
    bit  mw_seen = 0;
    bit  prev_pending = 0;
    bit  prev_done = 0;
    logic [15:0] prev_addr = '0;
    logic [15:0] prev_data = '0;

    // Memory/arbiter responder controls.
    int  ack_delay = 0;
    int  wait_cnt = 0;
    int  ack_issued = 0;
    int  gap_at = 0;
    int  gap_left = 0;
    bit  in_gap = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Responder: acks each write after ack_delay waiting cycles; optionally
    // removes grant for 5 cycles starting with the gap_at-th ack.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (gap_left > 0) begin
                gap_left--;
                if (gap_left == 0) begin
                    bus_grant = 1'b1;
                    in_gap    = 0;
                end else begin
                    in_gap = 1;
                end
            end
            if (mem_ack) wait_cnt = 0;
            mem_ack = 1'b0;
            if (mem_write) begin
                if (wait_cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    ack_issued++;
                    if (gap_at != 0 && ack_issued == gap_at) begin
                        bus_grant = 1'b0;
                        gap_left  = 5;
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
            end
        end
    end

    // Monitor / scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (mem_write && mem_ack) begin
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %0h data %0h, required no write",
                             mem_address, mem_data);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_addr", 64'(mem_address), 64'(e.a));
                    check("wr_data", 64'(mem_data), 64'(e.d));
                end
            end
            if (prev_pending && mem_write) begin
                check("stable_addr", 64'(mem_address), 64'(prev_addr));
                check("stable_data", 64'(mem_data), 64'(prev_data));
            end
            if (dma_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("done_one_cycle", 64'(prev_done), 64'(0));
            end
            if (bus_request) br_seen = 1;
            if (mem_write) mw_seen = 1;
            if (in_gap) begin
                check("gap_mem_write", 64'(mem_write), 64'(0));
                check("gap_bus_request", 64'(bus_request), 64'(1));
            end
        end
        prev_pending = reset_n && mem_write && !mem_ack;
        prev_addr    = mem_address;
        prev_data    = mem_data;
        prev_done    = reset_n && dma_done;
    end

    task automatic randomize_dev();
        for (int i = 0; i < 64; i++) dev_mem[i] = 16'($urandom);
    endtask

    task automatic start_job(input logic [15:0] a, input logic [15:0] l, input bit noise,
                             output int acc_cyc);
        int n = 0;
        logic [15:0] idx;
        while (!cmd_ready && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("cmd_ready_wait", 64'(cmd_ready), 64'(1));
        for (int i = 0; i < int'(l); i++) begin
            idx = 16'(i);
            exp_q.push_back('{a: a + idx, d: dev_mem[idx[5:0]]});
        end
        br_seen    = 0;
        mw_seen    = 0;
        done_cnt   = 0;
        wr_cnt     = 0;
        ack_issued = 0;
        cmd_valid  = 1'b1;
        cmd_addr   = a;
        cmd_length = l;
        acc_cyc    = cyc;
        @(posedge clk);
        #1;
        cmd_valid  = 1'b0;
        cmd_addr   = 16'($urandom);
        cmd_length = 16'($urandom);
        if (noise) begin
            repeat (3) @(posedge clk);
            #1;
            cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            cmd_valid = 1'b0;
        end
    endtask

    task automatic wait_job(input int len);
        int n = 0;
        while (done_cnt == 0 && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("done_seen", 64'(done_cnt != 0), 64'(1));
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("done_count", 64'(done_cnt), 64'(1));
        check("write_count", 64'(wr_cnt), 64'(len));
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        check("br_after_done", 64'(bus_request), 64'(0));
        check("ready_after_done", 64'(cmd_ready), 64'(1));
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
        check({tag, "_bus_request"}, 64'(bus_request), 64'(0));
        check({tag, "_mem_write"}, 64'(mem_write), 64'(0));
        check({tag, "_dma_done"}, 64'(dma_done), 64'(0));
        check({tag, "_dev_offset"}, 64'(dev_offset), 64'(0));
        check({tag, "_mem_address"}, 64'(mem_address), 64'(0));
        check({tag, "_mem_data"}, 64'(mem_data), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int n;
        int len;
        randomize_dev();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Basic 12-word transfer with a stray command while busy.
        start_job(16'h0100, 16'd12, 1'b1, acc);
        wait_job(12);

        // Zero length: no bus activity, prompt completion.
        start_job(16'h1234, 16'd0, 1'b0, acc);
        wait_job(0);
        check("zero_no_bus_request", 64'(br_seen), 64'(0));
        check("zero_no_mem_write", 64'(mw_seen), 64'(0));
        check("zero_done_latency", 64'((done_cyc - acc) >= 1 && (done_cyc - acc) <= 2), 64'(1));

        // Partial final burst.
        dev_mem[0] = 16'h1111; dev_mem[1] = 16'h2222; dev_mem[2] = 16'h3333; dev_mem[3] = 16'h4444;
        dev_mem[4] = 16'h5555; dev_mem[5] = 16'h6666; dev_mem[6] = 16'h7777; dev_mem[7] = 16'h8888;
        start_job(16'h0001, 16'd6, 1'b0, acc);
        wait_job(6);

        // Grant loss after the 2nd ack.
        randomize_dev();
        gap_at = 2;
        start_job(16'h0400, 16'd8, 1'b0, acc);
        wait_job(8);
        gap_at = 0;

        // Address wrap with slow memory.
        randomize_dev();
        ack_delay = 3;
        start_job(16'hFFFE, 16'd4, 1'b0, acc);
        wait_job(4);
        ack_delay = 0;

        // Randomized jobs.
        for (int j = 0; j < 6; j++) begin
            randomize_dev();
            len       = int'($urandom_range(1, 20));
            ack_delay = int'($urandom_range(0, 2));
            gap_at    = (len >= 2 && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, len - 1)) : 0;
            start_job(16'($urandom), 16'(len), 1'b0, acc);
            wait_job(len);
        end
        gap_at    = 0;
        ack_delay = 0;

        // Reset in the middle of a 12-word transfer.
        randomize_dev();
        start_job(16'h0200, 16'd12, 1'b0, acc);
        n = 0;
        while (wr_cnt < 5 && n < 500) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("reached_mid_write", 64'(wr_cnt >= 5), 64'(1));
        reset_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midreset");
        exp_q.delete();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        randomize_dev();
        start_job(16'h0300, 16'd8, 1'b0, acc);
        wait_job(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
